// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded operands, register specifiers and control bundles from ID.
// A load in EX whose destination matches a source register of the instruction
// in ID raises stall and turns the next capture into a bubble. Flush (taken
// branch) always produces a bubble. stallCount records load-use bubbles and
// saturates instead of wrapping.
module id_ex_register (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] immediate,
    input  logic [31:0] pcPlus4,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [1:0]  wbControlInput,   // {regWrite, memToReg}
    input  logic [2:0]  memControlInput,  // {branch, memRead, memWrite}
    input  logic [3:0]  exControlInput,   // {regDst, aluOp[1:0], aluSrc}
    input  logic        flush,

    output logic [31:0] readData1Out,
    output logic [31:0] readData2Out,
    output logic [31:0] immediateOut,
    output logic [31:0] pcPlus4Out,
    output logic [4:0]  rsOut,
    output logic [4:0]  rtOut,
    output logic [4:0]  rdOut,
    output logic [4:0]  writeRegOut,
    output logic [1:0]  wbControlOutput,
    output logic [2:0]  memControlOutput,
    output logic [3:0]  exControlOutput,

    output logic        stall,
    output logic [15:0] stallCount
);

    localparam logic [15:0] StallCountMax = 16'hFFFF;

    logic loadInEx;
    logic bubble;
    logic countStall;

    // Hazard detection: a load in EX writing a non-zero register read by ID.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        loadInEx   = 1'b0;
        stall      = 1'b0;
        bubble     = 1'b0;
        countStall = 1'b0;

        loadInEx = memControlOutput[1] && (rtOut != 5'd0);
        stall    = loadInEx && ((rtOut == rs) || (rtOut == rt));

        // Flush wins over stall: it bubbles but is not a load-use bubble.
        bubble     = flush || stall;
        countStall = stall && !flush;
    end

    // Pipeline register: data always advances, controls are zeroed on a bubble.
    // NOTE: asynchronous active-low reset in the sensitivity list; state is updated with non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readData1Out     <= '0;
            readData2Out     <= '0;
            immediateOut     <= '0;
            pcPlus4Out       <= '0;
            rsOut            <= '0;
            rtOut            <= '0;
            rdOut            <= '0;
            writeRegOut      <= '0;
            wbControlOutput  <= '0;
            memControlOutput <= '0;
            exControlOutput  <= '0;
        end else begin
            readData1Out <= readData1;
            readData2Out <= readData2;
            immediateOut <= immediate;
            pcPlus4Out   <= pcPlus4;
            rsOut        <= rs;
            rtOut        <= rt;
            rdOut        <= rd;
            // regDst selects the R-type destination, otherwise the I-type rt.
            writeRegOut  <= exControlInput[3] ? rd : rt;

            if (bubble) begin
                wbControlOutput  <= '0;
                memControlOutput <= '0;
                exControlOutput  <= '0;
            end else begin
                wbControlOutput  <= wbControlInput;
                memControlOutput <= memControlInput;
                exControlOutput  <= exControlInput;
            end
        end
    end

    // Load-use bubble counter, saturating at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCount <= '0;
        end else if (countStall && (stallCount != StallCountMax)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Directed testbench for id_ex_register.
// Inputs change on the falling edge; outputs are sampled 1 ns later or 1 ns
// after the rising edge.
module tb_id_ex_register;

    logic        clock;
    logic        reset;
    logic [31:0] readData1, readData2, immediate, pcPlus4;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  wbControlInput;
    logic [2:0]  memControlInput;
    logic [3:0]  exControlInput;
    logic        flush;

    logic [31:0] readData1Out, readData2Out, immediateOut, pcPlus4Out;
    logic [4:0]  rsOut, rtOut, rdOut, writeRegOut;
    logic [1:0]  wbControlOutput;
    logic [2:0]  memControlOutput;
    logic [3:0]  exControlOutput;
    logic        stall;
    logic [15:0] stallCount;

    int checkCount = 0;
    int errorCount = 0;

    id_ex_register dut (
        .clock            (clock),
        .reset            (reset),
        .readData1        (readData1),
        .readData2        (readData2),
        .immediate        (immediate),
        .pcPlus4          (pcPlus4),
        .rs               (rs),
        .rt               (rt),
        .rd               (rd),
        .wbControlInput   (wbControlInput),
        .memControlInput  (memControlInput),
        .exControlInput   (exControlInput),
        .flush            (flush),
        .readData1Out     (readData1Out),
        .readData2Out     (readData2Out),
        .immediateOut     (immediateOut),
        .pcPlus4Out       (pcPlus4Out),
        .rsOut            (rsOut),
        .rtOut            (rtOut),
        .rdOut            (rdOut),
        .writeRegOut      (writeRegOut),
        .wbControlOutput  (wbControlOutput),
        .memControlOutput (memControlOutput),
        .exControlOutput  (exControlOutput),
        .stall            (stall),
        .stallCount       (stallCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present one ID-stage instruction; the other data buses are derived from d1.
    task automatic setInstr(input logic [4:0] rsV, input logic [4:0] rtV, input logic [4:0] rdV,
                            input logic [1:0] wbV, input logic [2:0] memV, input logic [3:0] exV,
                            input logic [31:0] d1, input logic flushV);
        rs              = rsV;
        rt              = rtV;
        rd              = rdV;
        wbControlInput  = wbV;
        memControlInput = memV;
        exControlInput  = exV;
        readData1       = d1;
        readData2       = ~d1;
        immediate       = d1 ^ 32'h0000_FFFF;
        pcPlus4         = d1 + 32'd4;
        flush           = flushV;
    endtask

    task automatic checkControls(input string tag, input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex);
        check({tag, ".wb"},  {30'd0, wbControlOutput}, {30'd0, wb});
        check({tag, ".mem"}, {29'd0, memControlOutput}, {29'd0, mem});
        check({tag, ".ex"},  {28'd0, exControlOutput}, {28'd0, ex});
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".readData1Out"}, readData1Out, 32'd0);
        check({tag, ".readData2Out"}, readData2Out, 32'd0);
        check({tag, ".immediateOut"}, immediateOut, 32'd0);
        check({tag, ".pcPlus4Out"},   pcPlus4Out, 32'd0);
        check({tag, ".rsOut"},        {27'd0, rsOut}, 32'd0);
        check({tag, ".rtOut"},        {27'd0, rtOut}, 32'd0);
        check({tag, ".rdOut"},        {27'd0, rdOut}, 32'd0);
        check({tag, ".writeRegOut"},  {27'd0, writeRegOut}, 32'd0);
        checkControls(tag, 2'b00, 3'b000, 4'b0000);
        check({tag, ".stall"},        {31'd0, stall}, 32'd0);
        check({tag, ".stallCount"},   {16'd0, stallCount}, 32'd0);
    endtask

    // Advance through one rising edge and settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held low with arbitrary, hazard-looking inputs.
        reset = 1'b0;
        setInstr(5'd8, 5'd8, 5'd31, 2'b11, 3'b111, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        repeat (3) tick();
        checkAllZero("reset");

        // Capture with regDst=1.
        @(negedge clock);
        reset = 1'b1;
        setInstr(5'd3, 5'd4, 5'd5, 2'b10, 3'b000, 4'b1000, 32'h0000_1234, 1'b0);
        tick();
        check("cap.rsOut",        {27'd0, rsOut}, 32'd3);
        check("cap.rtOut",        {27'd0, rtOut}, 32'd4);
        check("cap.rdOut",        {27'd0, rdOut}, 32'd5);
        check("cap.writeRegOut",  {27'd0, writeRegOut}, 32'd5);
        check("cap.readData1Out", readData1Out, 32'h0000_1234);
        check("cap.readData2Out", readData2Out, 32'hFFFF_EDCB);
        check("cap.immediateOut", immediateOut, 32'h0000_EDCB);
        check("cap.pcPlus4Out",   pcPlus4Out, 32'h0000_1238);
        checkControls("cap", 2'b10, 3'b000, 4'b1000);
        check("cap.stall",        {31'd0, stall}, 32'd0);

        // Load (regDst=0 -> writeReg is rt).
        @(negedge clock);
        setInstr(5'd1, 5'd8, 5'd9, 2'b11, 3'b010, 4'b0001, 32'hA5A5_0001, 1'b0);
        tick();
        check("load.writeRegOut", {27'd0, writeRegOut}, 32'd8);
        checkControls("load", 2'b11, 3'b010, 4'b0001);

        // Dependent instruction reads r8 as rs -> load-use stall.
        @(negedge clock);
        setInstr(5'd8, 5'd2, 5'd3, 2'b10, 3'b000, 4'b1000, 32'h0BAD_0002, 1'b0);
        #1;
        check("lu.stallBefore", {31'd0, stall}, 32'd1);
        tick();
        checkControls("lu.bubble", 2'b00, 3'b000, 4'b0000);
        check("lu.rsOut",       {27'd0, rsOut}, 32'd8);
        check("lu.stallCount",  {16'd0, stallCount}, 32'd1);
        check("lu.stallAfter",  {31'd0, stall}, 32'd0);
        // Same instruction re-presented now captures normally.
        tick();
        checkControls("lu.retry", 2'b10, 3'b000, 4'b1000);
        check("lu.retryCount", {16'd0, stallCount}, 32'd1);

        // Load into $zero never stalls.
        @(negedge clock);
        setInstr(5'd0, 5'd0, 5'd0, 2'b10, 3'b010, 4'b0001, 32'h0000_0003, 1'b0);
        tick();
        @(negedge clock);
        setInstr(5'd0, 5'd0, 5'd6, 2'b10, 3'b000, 4'b1000, 32'h0000_0004, 1'b0);
        #1;
        check("zero.stall", {31'd0, stall}, 32'd0);
        tick();
        checkControls("zero.cap", 2'b10, 3'b000, 4'b1000);
        check("zero.writeRegOut", {27'd0, writeRegOut}, 32'd6);
        check("zero.stallCount",  {16'd0, stallCount}, 32'd1);

        // Hazard via rt operand plus flush: bubble, count unchanged.
        @(negedge clock);
        setInstr(5'd1, 5'd8, 5'd9, 2'b11, 3'b010, 4'b0001, 32'h0000_0005, 1'b0);
        tick();
        @(negedge clock);
        setInstr(5'd7, 5'd8, 5'd3, 2'b10, 3'b000, 4'b1000, 32'h0000_0006, 1'b1);
        #1;
        check("flush.stallBefore", {31'd0, stall}, 32'd1);
        tick();
        checkControls("flush.bubble", 2'b00, 3'b000, 4'b0000);
        check("flush.stallCount", {16'd0, stallCount}, 32'd1);
        check("flush.rtOut",      {27'd0, rtOut}, 32'd8);

        // Flush alone on a normal instruction also bubbles.
        @(negedge clock);
        setInstr(5'd2, 5'd3, 5'd4, 2'b10, 3'b001, 4'b1010, 32'h0000_0007, 1'b1);
        tick();
        checkControls("flushOnly", 2'b00, 3'b000, 4'b0000);
        check("flushOnly.readData1Out", readData1Out, 32'h0000_0007);

        // Saturation: preload the counter just below its maximum.
        @(negedge clock);
        force dut.stallCount = 16'hFFFE;
        #1;
        release dut.stallCount;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            setInstr(5'd1, 5'd8, 5'd9, 2'b11, 3'b010, 4'b0001, 32'h0000_0100 + i, 1'b0);
            tick();
            @(negedge clock);
            setInstr(5'd8, 5'd2, 5'd3, 2'b10, 3'b000, 4'b1000, 32'h0000_0200 + i, 1'b0);
            #1;
            check($sformatf("sat%0d.stall", i), {31'd0, stall}, 32'd1);
            tick();
            check($sformatf("sat%0d.stallCount", i), {16'd0, stallCount}, 32'h0000_FFFF);
            checkControls($sformatf("sat%0d.bubble", i), 2'b00, 3'b000, 4'b0000);
        end

        // Reset asserted mid-stall clears everything without a clock edge.
        @(negedge clock);
        setInstr(5'd1, 5'd8, 5'd9, 2'b11, 3'b010, 4'b0001, 32'h0000_0300, 1'b0);
        tick();
        @(negedge clock);
        setInstr(5'd8, 5'd8, 5'd3, 2'b10, 3'b000, 4'b1000, 32'h0000_0301, 1'b0);
        #1;
        check("rstMid.stallBefore", {31'd0, stall}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        checkAllZero("rstMid");
        @(negedge clock);
        reset = 1'b1;
        tick();
        checkControls("rstRel", 2'b10, 3'b000, 4'b1000);
        check("rstRel.writeRegOut", {27'd0, writeRegOut}, 32'd3);
        check("rstRel.stallCount",  {16'd0, stallCount}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
